// File: rtl/tx_framer_if.sv
// Word stream bundle shared by the plaintext input and the framed output.
// Handshake: a word transfers on a rising clock edge where tvalid and tready
// are both high; the sender holds tvalid/tdata/sof/eof stable until then.
interface tx_framer_if;
    logic        tvalid;
    logic        tready;
    logic [31:0] tdata;
    logic        sof;
    logic        eof;

    // Framed output side: drives data and frame flags.
    modport master (output tvalid, output tdata, output sof, output eof, input tready);

    // Plaintext input side: frame flags are not carried on this stream.
    modport slave (input tvalid, input tdata, output tready);
endinterface

// File: rtl/tx_framer.sv
// Transmit framer: XORs plaintext words with a 32-bit PRBS keystream and emits
// fixed-length frames with start/end-of-frame flags through a one-word output
// register. o_busy is the FSM state (high while in SEND).
module tx_framer #(
    parameter int C_FRAME_LEN_WIDTH = 16
) (
    input  logic                         s_axi_aclk,
    input  logic                         s_axi_aresetn,
    input  logic                         i_tx_enable,
    input  logic                         i_prbs_reload,
    input  logic [31:0]                  i_prbs_seed,
    input  logic [C_FRAME_LEN_WIDTH-1:0] i_frame_len,
    tx_framer_if.slave                   s_axis,
    tx_framer_if.master                  m_axis,
    output logic                         o_busy,
    output logic [31:0]                  o_frame_count
);

    localparam logic [C_FRAME_LEN_WIDTH-1:0] C_ONE = {{(C_FRAME_LEN_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                       r_state;
    state_t                       w_next_state;
    logic                         r_en_d;
    logic [C_FRAME_LEN_WIDTH-1:0] r_len;
    logic [C_FRAME_LEN_WIDTH-1:0] r_count;
    logic [31:0]                  r_lfsr;
    logic [31:0]                  r_tdata;
    logic                         r_tvalid;
    logic                         r_sof;
    logic                         r_eof;
    logic [31:0]                  r_frame_count;

    logic                         w_tready;
    logic                         w_accept;
    logic                         w_out_fire;
    logic                         w_last;
    logic [C_FRAME_LEN_WIDTH-1:0] w_len_eff;
    logic [31:0]                  w_lfsr_next;

    // Input is taken only in SEND and only when the output register is free
    // or emptying this cycle, so backpressure reaches the source immediately.
    assign w_tready    = (r_state == SEND) & (~r_tvalid | m_axis.tready);
    assign w_accept    = s_axis.tvalid & w_tready;
    assign w_out_fire  = r_tvalid & m_axis.tready;
    assign w_last      = (r_count == (r_len - C_ONE));
    assign w_len_eff   = (i_frame_len == '0) ? C_ONE : i_frame_len;
    assign w_lfsr_next = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

    assign s_axis.tready = w_tready;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.sof    = r_sof;
    assign m_axis.eof    = r_eof;
    assign o_busy        = (r_state == SEND);
    assign o_frame_count = r_frame_count;

    // Next-state logic: a frame never truncates; it ends only on its eof accept.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (r_en_d) w_next_state = SEND;
            SEND: if (w_accept && w_last) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // State register, registered enable, frame length latch and beat counter.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_state <= IDLE;
            r_en_d  <= 1'b0;
            r_len   <= C_ONE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            r_en_d  <= i_tx_enable;
            if (r_state == IDLE && r_en_d) begin
                r_len   <= w_len_eff;
                r_count <= '0;
            end else if (w_accept) begin
                r_count <= r_count + C_ONE;
            end
        end
    end

    // Keystream LFSR: a reload takes priority over the advance from an accept.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_lfsr <= 32'h0000_0001;
        end else if (i_prbs_reload) begin
            r_lfsr <= (i_prbs_seed == 32'h0) ? 32'h0000_0001 : i_prbs_seed;
        end else if (w_accept) begin
            r_lfsr <= w_lfsr_next;
        end
    end

    // Output register: loads on accept, empties on handshake, holds while stalled.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_tvalid <= 1'b0;
            r_tdata  <= 32'h0;
            r_sof    <= 1'b0;
            r_eof    <= 1'b0;
        end else if (w_accept) begin
            r_tvalid <= 1'b1;
            r_tdata  <= s_axis.tdata ^ r_lfsr;
            r_sof    <= (r_count == '0);
            r_eof    <= w_last;
        end else if (w_out_fire) begin
            r_tvalid <= 1'b0;
        end
    end

    // Completed-frame counter: counts eof words as they leave; wraps naturally.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_frame_count <= 32'h0;
        end else if (w_out_fire && r_eof) begin
            r_frame_count <= r_frame_count + 32'h1;
        end
    end

endmodule
